msrv32_wb_arbiter: RTL and testbench
====================================

MSRV32_WB_ARBITER -- requirements
Module: msrv32_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: late-result buffer entries; legal values 2 or 4.
REQ-002 Parameter MAX_WAIT, default 4: cycles a buffered head may be denied before the pipeline is stalled; legal range 1..15.
REQ-003 ms_riscv32_mp_clk_in  in  1  clock; all state updates on the rising edge.
REQ-004 ms_riscv32_mp_rst_n_in  in  1  reset, asynchronous, active-low.
REQ-005 pipe_wr_en_in  in  1  in-order pipeline requests a register-file write this cycle.
REQ-006 pipe_rd_addr_in  in  5  pipeline destination register.
REQ-007 pipe_wb_data_in  in  32  pipeline write-back data, taken from the write-back mux output.
REQ-008 late_valid_in  in  1  long-latency unit offers a result.
REQ-009 late_rd_addr_in  in  5  destination register of the late result.
REQ-010 late_data_in  in  32  late result data.
REQ-011 late_ready_out  out  1  arbiter can accept a late result.
REQ-012 rf_wr_en_out  out  1  registered register-file write enable.
REQ-013 rf_rd_addr_out  out  5  registered write address.
REQ-014 rf_wr_data_out  out  32  registered write data.
REQ-015 stall_pipe_out  out  1  registered stall request to the pipeline.
REQ-016 buf_count_out  out  3  number of valid entries in the late buffer.

Function
REQ-017 The block SHALL accept a late result when late_valid_in and late_ready_out are both high in the same cycle.
REQ-018 late_ready_out SHALL be high only when buf_count_out < DEPTH, evaluated before any same-cycle pop; a full buffer does not accept a result in a cycle where it pops.
REQ-019 An accepted late result with rd = 0 SHALL be consumed and discarded without being enqueued.
REQ-020 The buffer SHALL be FIFO-ordered, with one push and one pop allowed per cycle.
REQ-021 The FSM SHALL have two states: NORMAL and STALL.
REQ-022 In NORMAL, priority SHALL be: (1) pipe_wr_en_in with pipe_rd_addr_in != 0 is granted; (2) otherwise the buffer head is granted if the buffer is non-empty; (3) otherwise no write.
REQ-023 In STALL, the buffer head SHALL be granted, pipe_wr_en_in SHALL be ignored, and the pipeline re-presents its write after the stall.
REQ-024 A pipeline write with rd = 0 SHALL NOT be written and SHALL count as no request.
REQ-025 Each grant SHALL register rf_wr_en_out=1 with the granted rd and data on the next edge, giving 1-cycle latency; otherwise rf_wr_en_out=0 and address/data hold their previous values.
REQ-026 Late results always belong to older instructions (WAW rule): a granted pipeline write to rd X SHALL invalidate every buffered entry with rd X.
REQ-027 A late result accepted in the same cycle as a granted pipeline write to the same rd SHALL be enqueued already invalid.
REQ-028 An invalid head SHALL be popped when granted without producing an rf write.
REQ-029 A wait counter (4 bits) SHALL increment each NORMAL cycle in which the buffer is non-empty and its head is not granted, and SHALL clear on any head pop or when the buffer is empty.
REQ-030 When the wait counter equals MAX_WAIT-1 and the head is denied, the FSM SHALL go NORMAL->STALL, with stall_pipe_out=1 from the next cycle.
REQ-031 STALL SHALL last exactly one cycle and then return to NORMAL, with stall_pipe_out=0 and the counter cleared.
REQ-032 buf_count_out SHALL count both valid and invalid entries and SHALL update on the edge following a push or pop; a simultaneous push and pop leaves it unchanged.

Reset
REQ-033 While ms_riscv32_mp_rst_n_in is low, the block SHALL hold FSM=NORMAL, the buffer empty, buf_count_out=0, wait counter=0, rf_wr_en_out=0, rf_rd_addr_out=0, rf_wr_data_out=0, stall_pipe_out=0, late_ready_out=1.
REQ-034 Reset asserted mid-operation SHALL discard all buffered entries without writing them and take effect immediately, without waiting for a clock edge.

Verification
REQ-035 Pipeline only: pipe write rd=5, data 0xDEADBEEF at cycle N -> rf_wr_en_out=1, rd=5, data 0xDEADBEEF at cycle N+1; a pipe write with rd=0 -> no write.
REQ-036 Contention: late rd=7/0x11 accepted at N with the pipe idle at N+1 -> rf write rd=7/0x11 at N+2; with the pipe busy every cycle and MAX_WAIT=4 -> stall_pipe_out=1 for one cycle and rd=7 written during the cycle after that stall cycle.
REQ-037 Full buffer: DEPTH=2, two accepts while the pipe is busy -> late_ready_out=0 and buf_count_out=2; a third offer with a simultaneous pop is not accepted.
REQ-038 WAW: late rd=9/0xAA buffered, then pipe write rd=9/0xBB -> only 0xBB is written to rd 9; the stale entry pops with no write and buf_count_out decrements.
REQ-039 Async reset: assert reset mid-cycle with 2 entries buffered and STALL active -> all outputs go to reset values immediately; after release, no stale writes occur.

Source files
------------

// File: rtl/msrv32_wb_arbiter.sv
// rtl/msrv32_wb_arbiter.sv - register-file write-back arbiter between the in-order pipeline and a late-result buffer
// Late results wait in a small FIFO and are written when the pipeline leaves a free write slot.
module msrv32_wb_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_n_in,
   input  logic        pipe_wr_en_in,
   input  logic [4:0]  pipe_rd_addr_in,
   input  logic [31:0] pipe_wb_data_in,
   input  logic        late_valid_in,
   input  logic [4:0]  late_rd_addr_in,
   input  logic [31:0] late_data_in,
   output logic        late_ready_out,
   output logic        rf_wr_en_out,
   output logic [4:0]  rf_rd_addr_out,
   output logic [31:0] rf_wr_data_out,
   output logic        stall_pipe_out,
   output logic [2:0]  buf_count_out
);

   localparam int         PTR_W     = $clog2(DEPTH);
   localparam logic       NORMAL    = 1'b0;
   localparam logic       STALL     = 1'b1;
   localparam logic [2:0] DEPTH_C   = 3'(DEPTH);
   localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

   logic             state;
   logic [3:0]       wait_cnt;
   logic [2:0]       count;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [4:0]       buf_rd   [DEPTH];
   logic [31:0]      buf_data [DEPTH];
   logic [DEPTH-1:0] buf_vld;

   logic buf_empty;
   logic pipe_req;
   logic grant_pipe;
   logic grant_head;
   logic head_denied;
   logic push;
   logic push_vld;

   always_comb begin
      buf_empty   = (count == 3'd0);
      pipe_req    = pipe_wr_en_in && (pipe_rd_addr_in != 5'd0);
      grant_pipe  = (state == NORMAL) && pipe_req;
      grant_head  = !buf_empty && ((state == STALL) || !pipe_req);
      head_denied = (state == NORMAL) && !buf_empty && !grant_head;
      // rd=0 results are consumed but never stored
      push        = late_valid_in && late_ready_out && (late_rd_addr_in != 5'd0);
      // a same-cycle pipeline write to the same rd is younger, so the late result is dead on arrival
      push_vld    = !(grant_pipe && (late_rd_addr_in == pipe_rd_addr_in));
   end

   assign late_ready_out = (count < DEPTH_C);
   assign stall_pipe_out = (state == STALL);
   assign buf_count_out  = count;

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         state    <= NORMAL;
         wait_cnt <= 4'd0;
         count    <= 3'd0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         buf_vld  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_rd[i]   <= 5'd0;
            buf_data[i] <= 32'd0;
         end
      end else begin
         if ((state == NORMAL) && head_denied && (wait_cnt == WAIT_LAST))
            state <= STALL;
         else
            state <= NORMAL;

         if ((state == STALL) || buf_empty || grant_head || (wait_cnt == WAIT_LAST))
            wait_cnt <= 4'd0;
         else
            wait_cnt <= wait_cnt + 4'd1;

         // WAW: buffered results are older than any granted pipeline write
         for (int i = 0; i < DEPTH; i++) begin
            if (grant_pipe && (buf_rd[i] == pipe_rd_addr_in))
               buf_vld[i] <= 1'b0;
         end

         if (push) begin
            buf_rd[wr_ptr]   <= late_rd_addr_in;
            buf_data[wr_ptr] <= late_data_in;
            buf_vld[wr_ptr]  <= push_vld;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (grant_head)
            rd_ptr <= rd_ptr + PTR_W'(1);

         count <= count + {2'b00, push} - {2'b00, grant_head};
      end
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         rf_wr_en_out   <= 1'b0;
         rf_rd_addr_out <= 5'd0;
         rf_wr_data_out <= 32'd0;
      end else if (grant_pipe) begin
         rf_wr_en_out   <= 1'b1;
         rf_rd_addr_out <= pipe_rd_addr_in;
         rf_wr_data_out <= pipe_wb_data_in;
      end else if (grant_head && buf_vld[rd_ptr]) begin
         rf_wr_en_out   <= 1'b1;
         rf_rd_addr_out <= buf_rd[rd_ptr];
         rf_wr_data_out <= buf_data[rd_ptr];
      end else begin
         rf_wr_en_out   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
// tb/tb_msrv32_wb_arbiter.sv - directed vector bench for msrv32_wb_arbiter
// Each row drives one cycle of inputs; expectations are the outputs after that rising edge.
module tb_msrv32_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        pipe_wr_en;
   logic [4:0]  pipe_rd_addr;
   logic [31:0] pipe_wb_data;
   logic        late_valid;
   logic [4:0]  late_rd_addr;
   logic [31:0] late_data;
   logic        late_ready;
   logic        rf_wr_en;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_wr_data;
   logic        stall_pipe;
   logic [2:0]  buf_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        pe;
      logic [4:0]  prd;
      logic [31:0] pd;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ld;
      logic        en;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        st;
      logic [2:0]  cnt;
      logic        rdy;
   } vec_t;

   vec_t vecs [23];

   msrv32_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
      .ms_riscv32_mp_clk_in   (clk),
      .ms_riscv32_mp_rst_n_in (rst_n),
      .pipe_wr_en_in          (pipe_wr_en),
      .pipe_rd_addr_in        (pipe_rd_addr),
      .pipe_wb_data_in        (pipe_wb_data),
      .late_valid_in          (late_valid),
      .late_rd_addr_in        (late_rd_addr),
      .late_data_in           (late_data),
      .late_ready_out         (late_ready),
      .rf_wr_en_out           (rf_wr_en),
      .rf_rd_addr_out         (rf_rd_addr),
      .rf_wr_data_out         (rf_wr_data),
      .stall_pipe_out         (stall_pipe),
      .buf_count_out          (buf_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(logic pe, logic [4:0] prd, logic [31:0] pd,
                               logic lv, logic [4:0] lrd, logic [31:0] ld,
                               logic en, logic [4:0] rd, logic [31:0] data,
                               logic st, logic [2:0] cnt, logic rdy);
      vec_t v;
      v.pe = pe; v.prd = prd; v.pd = pd; v.lv = lv; v.lrd = lrd; v.ld = ld;
      v.en = en; v.rd = rd; v.data = data; v.st = st; v.cnt = cnt; v.rdy = rdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input vec_t v);
      chk({tag, " rf_wr_en"},   {31'd0, rf_wr_en},   {31'd0, v.en});
      chk({tag, " rf_rd_addr"}, {27'd0, rf_rd_addr}, {27'd0, v.rd});
      chk({tag, " rf_wr_data"}, rf_wr_data,          v.data);
      chk({tag, " stall"},      {31'd0, stall_pipe}, {31'd0, v.st});
      chk({tag, " buf_count"},  {29'd0, buf_count},  {29'd0, v.cnt});
      chk({tag, " late_ready"}, {31'd0, late_ready}, {31'd0, v.rdy});
   endtask

   task automatic apply(input string tag, input vec_t v);
      pipe_wr_en   = v.pe;
      pipe_rd_addr = v.prd;
      pipe_wb_data = v.pd;
      late_valid   = v.lv;
      late_rd_addr = v.lrd;
      late_data    = v.ld;
      @(posedge clk);
      #1;
      chk_outputs(tag, v);
   endtask

   initial begin
      vec_t rst_v;
      vec_t idle_v;

      //              pe prd  pd            lv lrd   ld            en rd    data          st cnt   rdy
      vecs[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        1, 5'd5, 32'hDEADBEEF, 0, 3'd0, 1);
      vecs[1]  = mk(1, 5'd0, 32'h12345678, 0, 5'd0, 32'h0,        0, 5'd5, 32'hDEADBEEF, 0, 3'd0, 1);
      vecs[2]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd5, 32'hDEADBEEF, 0, 3'd0, 1);
      vecs[3]  = mk(0, 5'd0, 32'h0,        1, 5'd7, 32'h11,       0, 5'd5, 32'hDEADBEEF, 0, 3'd1, 1);
      vecs[4]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd7, 32'h11,       0, 3'd0, 1);
      vecs[5]  = mk(1, 5'd1, 32'h100,      1, 5'd7, 32'h11,       1, 5'd1, 32'h100,      0, 3'd1, 1);
      vecs[6]  = mk(1, 5'd2, 32'h200,      0, 5'd0, 32'h0,        1, 5'd2, 32'h200,      0, 3'd1, 1);
      vecs[7]  = mk(1, 5'd3, 32'h300,      0, 5'd0, 32'h0,        1, 5'd3, 32'h300,      0, 3'd1, 1);
      vecs[8]  = mk(1, 5'd4, 32'h400,      0, 5'd0, 32'h0,        1, 5'd4, 32'h400,      0, 3'd1, 1);
      vecs[9]  = mk(1, 5'd5, 32'h500,      0, 5'd0, 32'h0,        1, 5'd5, 32'h500,      1, 3'd1, 1);
      vecs[10] = mk(1, 5'd6, 32'h600,      0, 5'd0, 32'h0,        1, 5'd7, 32'h11,       0, 3'd0, 1);
      vecs[11] = mk(1, 5'd6, 32'h600,      0, 5'd0, 32'h0,        1, 5'd6, 32'h600,      0, 3'd0, 1);
      vecs[12] = mk(1, 5'd1, 32'hA1,       1, 5'd10, 32'h1010,    1, 5'd1, 32'hA1,       0, 3'd1, 1);
      vecs[13] = mk(1, 5'd2, 32'hA2,       1, 5'd11, 32'h1111,    1, 5'd2, 32'hA2,       0, 3'd2, 0);
      vecs[14] = mk(0, 5'd0, 32'h0,        1, 5'd12, 32'h1212,    1, 5'd10, 32'h1010,    0, 3'd1, 1);
      vecs[15] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd11, 32'h1111,    0, 3'd0, 1);
      vecs[16] = mk(0, 5'd0, 32'h0,        1, 5'd9, 32'hAA,       0, 5'd11, 32'h1111,    0, 3'd1, 1);
      vecs[17] = mk(1, 5'd9, 32'hBB,       0, 5'd0, 32'h0,        1, 5'd9, 32'hBB,       0, 3'd1, 1);
      vecs[18] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd9, 32'hBB,       0, 3'd0, 1);
      vecs[19] = mk(1, 5'd8, 32'hC8,       1, 5'd8, 32'h88,       1, 5'd8, 32'hC8,       0, 3'd1, 1);
      vecs[20] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd8, 32'hC8,       0, 3'd0, 1);
      vecs[21] = mk(0, 5'd0, 32'h0,        1, 5'd0, 32'h77,       0, 5'd8, 32'hC8,       0, 3'd0, 1);
      vecs[22] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd8, 32'hC8,       0, 3'd0, 1);

      rst_v  = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 3'd0, 1);
      idle_v = rst_v;

      rst_n        = 1'b0;
      pipe_wr_en   = 1'b0;
      pipe_rd_addr = 5'd0;
      pipe_wb_data = 32'd0;
      late_valid   = 1'b0;
      late_rd_addr = 5'd0;
      late_data    = 32'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_outputs("reset", rst_v);
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++)
         apply($sformatf("row%0d", i), vecs[i]);

      // Fill both entries behind a busy pipeline until the stall fires, then reset mid-cycle.
      apply("seq0", mk(1, 5'd1, 32'h1, 1, 5'd13, 32'hD, 1, 5'd1, 32'h1, 0, 3'd1, 1));
      apply("seq1", mk(1, 5'd2, 32'h2, 1, 5'd14, 32'hE, 1, 5'd2, 32'h2, 0, 3'd2, 0));
      apply("seq2", mk(1, 5'd3, 32'h3, 0, 5'd0,  32'h0, 1, 5'd3, 32'h3, 0, 3'd2, 0));
      apply("seq3", mk(1, 5'd4, 32'h4, 0, 5'd0,  32'h0, 1, 5'd4, 32'h4, 0, 3'd2, 0));
      apply("seq4", mk(1, 5'd5, 32'h5, 0, 5'd0,  32'h0, 1, 5'd5, 32'h5, 1, 3'd2, 0));
      #2;
      rst_n = 1'b0;
      #1;
      chk_outputs("async_rst", rst_v);
      pipe_wr_en = 1'b0;
      @(posedge clk);
      #1;
      chk_outputs("rst_held", rst_v);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++)
         apply($sformatf("post_rst%0d", i), idle_v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
